// File: rtl/acc_store_buffer.sv
// Store buffer between the accumulator and the data-memory write port.
// Holds {addr, data} entries in FIFO order, drains over valid/ready, forwards to loads.
module acc_store_buffer #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 5,
    parameter int DEPTH      = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    st_en,
    input  logic [ADDR_WIDTH-1:0]   st_addr,
    input  logic [DATA_WIDTH-1:0]   acc_in,
    output logic                    buf_full,
    output logic                    buf_empty,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    ovf,
    output logic                    mem_wr_valid,
    input  logic                    mem_wr_ready,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_data,
    input  logic [ADDR_WIDTH-1:0]   fwd_addr,
    output logic                    fwd_hit,
    output logic [DATA_WIDTH-1:0]   fwd_data
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DEPTH-1:0][ADDR_WIDTH-1:0] addr_q;
    logic [DEPTH-1:0][DATA_WIDTH-1:0] data_q;
    logic [DEPTH-1:0]                 valid_q;
    logic [PW-1:0]                    head;
    logic [PW-1:0]                    tail;
    logic                             enq;
    logic                             deq;

    assign buf_full     = (count == CW'(DEPTH));
    assign buf_empty    = (count == '0);
    assign mem_wr_valid = !buf_empty;

    // Full blocks stores outright, even if the head drains on this same edge.
    assign enq = st_en && !buf_full;
    assign deq = mem_wr_valid && mem_wr_ready;

    assign mem_addr = mem_wr_valid ? addr_q[head] : '0;
    assign mem_data = mem_wr_valid ? data_q[head] : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            ovf     <= 1'b0;
            valid_q <= '0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            if (st_en && buf_full)
                ovf <= 1'b1;
            if (deq) begin
                valid_q[head] <= 1'b0;
                head          <= head + PW'(1);
            end
            if (enq) begin
                addr_q[tail]  <= st_addr;
                data_q[tail]  <= acc_in;
                valid_q[tail] <= 1'b1;
                tail          <= tail + PW'(1);
            end
            case ({enq, deq})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Walk oldest to youngest so a later match overrides an earlier one.
    always_comb begin
        logic [PW-1:0] idx;
        fwd_hit  = 1'b0;
        fwd_data = '0;
        idx      = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head + PW'(k);
            if (valid_q[idx] && addr_q[idx] == fwd_addr) begin
                fwd_hit  = 1'b1;
                fwd_data = data_q[idx];
            end
        end
    end
endmodule

// File: tb/tb_acc_store_buffer.sv
// Directed plus randomized checks of acc_store_buffer against a queue-based reference model.
module tb_acc_store_buffer;
    localparam int DW = 8;
    localparam int AW = 5;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          st_en = 1'b0;
    logic [AW-1:0] st_addr = '0;
    logic [DW-1:0] acc_in = '0;
    logic          buf_full, buf_empty, ovf, mem_wr_valid, fwd_hit;
    logic [2:0]    count;
    logic          mem_wr_ready = 1'b0;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data;
    logic [AW-1:0] fwd_addr = '0;
    logic [DW-1:0] fwd_data;

    acc_store_buffer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .st_en(st_en), .st_addr(st_addr), .acc_in(acc_in),
        .buf_full(buf_full), .buf_empty(buf_empty), .count(count), .ovf(ovf),
        .mem_wr_valid(mem_wr_valid), .mem_wr_ready(mem_wr_ready),
        .mem_addr(mem_addr), .mem_data(mem_data),
        .fwd_addr(fwd_addr), .fwd_hit(fwd_hit), .fwd_data(fwd_data)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference state: pending stores oldest-first, plus every write memory accepted.
    logic [AW+DW-1:0] mq[$];
    logic [AW+DW-1:0] wr_log[$];
    logic             m_ovf = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic          e_hit;
        logic [DW-1:0] e_fd;
        e_hit = 1'b0;
        e_fd  = '0;
        for (int i = mq.size() - 1; i >= 0; i--) begin
            if (mq[i][AW+DW-1:DW] == fwd_addr) begin
                e_hit = 1'b1;
                e_fd  = mq[i][DW-1:0];
                break;
            end
        end
        chk({tag, ".count"}, 32'(count), 32'(mq.size()));
        chk({tag, ".full"}, 32'(buf_full), 32'(mq.size() == DEPTH));
        chk({tag, ".empty"}, 32'(buf_empty), 32'(mq.size() == 0));
        chk({tag, ".valid"}, 32'(mem_wr_valid), 32'(mq.size() != 0));
        chk({tag, ".addr"}, 32'(mem_addr), mq.size() != 0 ? 32'(mq[0][AW+DW-1:DW]) : 32'd0);
        chk({tag, ".data"}, 32'(mem_data), mq.size() != 0 ? 32'(mq[0][DW-1:0]) : 32'd0);
        chk({tag, ".ovf"}, 32'(ovf), 32'(m_ovf));
        chk({tag, ".fwd_hit"}, 32'(fwd_hit), 32'(e_hit));
        chk({tag, ".fwd_data"}, 32'(fwd_data), 32'(e_fd));
    endtask

    // One clock: drive inputs, advance the model by the same edge, then check.
    task automatic cyc(input string tag, input logic r, input logic se, input logic [AW-1:0] sa,
                       input logic [DW-1:0] d, input logic rdy, input logic [AW-1:0] fa);
        logic was_full, do_deq;
        rst = r; st_en = se; st_addr = sa; acc_in = d; mem_wr_ready = rdy; fwd_addr = fa;
        was_full = (mq.size() == DEPTH);
        do_deq   = (mq.size() != 0) && rdy;
        @(posedge clk);
        if (r) begin
            mq.delete();
            m_ovf = 1'b0;
        end else begin
            if (do_deq) wr_log.push_back(mq.pop_front());
            if (se && !was_full) mq.push_back({sa, d});
            if (se && was_full) m_ovf = 1'b1;
        end
        #1;
        check_all(tag);
    endtask

    initial begin
        logic [AW+DW-1:0] w;
        // Reset held two cycles
        cyc("rst0", 1, 0, 0, 0, 0, 0);
        cyc("rst1", 1, 0, 0, 0, 0, 0);
        chk("rst.empty_const", 32'(buf_empty), 32'd1);

        // Single store, ready high
        cyc("single", 0, 1, 5'h03, 8'hA5, 1, 5'h03);
        chk("single.addr_const", 32'(mem_addr), 32'h03);
        chk("single.data_const", 32'(mem_data), 32'hA5);
        cyc("single_drain", 0, 0, 0, 0, 1, 5'h03);
        chk("single.empty_const", 32'(buf_empty), 32'd1);

        // Back-pressure: entry must hold steady while ready is low
        wr_log.delete();
        cyc("bp_st", 0, 1, 5'h01, 8'h11, 0, 0);
        for (int i = 0; i < 5; i++) cyc("bp_hold", 0, 0, 0, 0, 0, 0);
        chk("bp.hold_data_const", 32'(mem_data), 32'h11);
        cyc("bp_go", 0, 0, 0, 0, 1, 0);
        cyc("bp_idle", 0, 0, 0, 0, 1, 0);
        chk("bp.write_count", 32'(wr_log.size()), 32'd1);

        // Fill to DEPTH, then overflow attempt
        wr_log.delete();
        for (int i = 1; i <= 4; i++) cyc("fill", 0, 1, AW'(i), DW'(i), 0, 0);
        chk("fill.full_const", 32'(buf_full), 32'd1);
        cyc("ovf", 0, 1, 5'h1F, 8'hEE, 0, 0);
        chk("ovf.const", 32'(ovf), 32'd1);
        cyc("ovf_ready", 0, 1, 5'h1E, 8'hEE, 1, 0);  // full blocks despite draining edge
        for (int i = 0; i < 5; i++) cyc("drain", 0, 0, 0, 0, 1, 0);
        chk("drain.n", 32'(wr_log.size()), 32'd4);
        for (int i = 1; i <= 4; i++) begin
            w = (wr_log.size() != 0) ? wr_log.pop_front() : '1;
            chk("drain.order", 32'(w[DW-1:0]), 32'(i));
        end

        // Simultaneous enqueue/dequeue at count 2
        cyc("sim_a", 0, 1, 5'h02, 8'h21, 0, 0);
        cyc("sim_b", 0, 1, 5'h02, 8'h22, 0, 0);
        cyc("sim_both", 0, 1, 5'h02, 8'h23, 1, 5'h02);
        chk("sim.count_const", 32'(count), 32'd2);
        chk("sim.head_const", 32'(mem_data), 32'h22);
        cyc("sim_both2", 0, 1, 5'h04, 8'h24, 1, 5'h02);
        for (int i = 0; i < 3; i++) cyc("sim_drain", 0, 0, 0, 0, 1, 0);

        // Forwarding, youngest wins; then reset mid-operation
        cyc("fwd_a", 0, 1, 5'h07, 8'h10, 0, 5'h07);
        cyc("fwd_b", 0, 1, 5'h07, 8'h20, 0, 5'h07);
        chk("fwd.data_const", 32'(fwd_data), 32'h20);
        cyc("fwd_miss", 0, 0, 0, 0, 0, 5'h08);
        chk("fwd.miss_const", 32'(fwd_hit), 32'd0);
        wr_log.delete();
        cyc("mid_rst", 1, 0, 0, 0, 1, 5'h07);
        cyc("post_rst", 0, 0, 0, 0, 1, 5'h07);
        chk("mid_rst.no_writes", 32'(wr_log.size()), 32'd0);
        chk("mid_rst.valid_const", 32'(mem_wr_valid), 32'd0);

        // Randomized traffic with narrow addresses to exercise forwarding
        for (int i = 0; i < 400; i++) begin
            cyc("rand", ($urandom_range(0, 99) == 0), $urandom_range(0, 1) == 1,
                AW'($urandom_range(0, 3)), DW'($urandom), $urandom_range(0, 2) != 0,
                AW'($urandom_range(0, 4)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
